// File: rtl/decode_pipe.sv
// decode_pipe: instruction decoder feeding a 2-entry record FIFO with legal-decode counter
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_uses_rs2,
  output logic             out_wb,
  output logic             out_illegal,
  output logic [CNT_W-1:0] decode_cnt
);
  typedef struct packed {
    logic            illegal;
    logic            wb;
    logic            uses_rs2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs2;
    logic [4:0]      rs1;
    logic [4:0]      rd;
  } rec_t;
  rec_t d, e0, e1;
  logic [1:0] cnt;
  logic [6:0] op;
  logic legal, no_rd, no_rs2, push, pop;
  logic unused_funct3;
  assign unused_funct3 = ^in_instr[14:12];
  assign in_ready  = !cnt[1];
  assign out_valid = cnt != 2'd0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_rd       = e0.rd;
  assign out_rs1      = e0.rs1;
  assign out_rs2      = e0.rs2;
  assign out_imm      = e0.imm;
  assign out_alu_op   = e0.alu_op;
  assign out_uses_rs2 = e0.uses_rs2;
  assign out_wb       = e0.wb;
  assign out_illegal  = e0.illegal;
  // decode the incoming word into a record; stores/branches have no rd, loads/addi no rs2
  always_comb begin
    d          = '0;
    op         = in_instr[6:0];
    legal      = op >= 7'd1 && op <= 7'd14;
    no_rd      = op == 7'd12 || op == 7'd14;
    no_rs2     = op == 7'd11 || op == 7'd13;
    d.illegal  = !legal;
    d.alu_op   = legal ? op[3:0] : 4'd0;
    d.rd       = legal && !no_rd ? in_instr[11:7] : 5'd0;
    d.rs1      = legal ? in_instr[19:15] : 5'd0;
    d.rs2      = legal && !no_rs2 ? in_instr[24:20] : 5'd0;
    d.uses_rs2 = legal && !no_rs2;
    d.wb       = legal && !no_rd && in_instr[11:7] != 5'd0;
    d.imm      = no_rs2 ? {{(XLEN-12){in_instr[31]}}, in_instr[31:20]} :
                 op == 7'd12 ? {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                 op == 7'd14 ? {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                 '0;
  end
  // shift-style FIFO: e0 is always the head, e1 the tail when two are held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      e0         <= '0;
      e1         <= '0;
      decode_cnt <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      if (pop) e0 <= (push && cnt == 2'd1) ? d : e1;
      else if (push && cnt == 2'd0) e0 <= d;
      if (push && !pop && cnt == 2'd1) e1 <= d;
      if (push && legal) decode_cnt <= decode_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed vectors checked against a queue-based behavioural model
module tb_decode_pipe;
  logic        clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic        in_ready, out_valid, out_uses_rs2, out_wb, out_illegal;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic [15:0] decode_cnt;
  int vecs = 0, errs = 0, mcnt = 0, pops = 0;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        u, wb, ill;
  } rec_t;
  rec_t q[$];

  decode_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_alu_op(out_alu_op),
    .out_uses_rs2(out_uses_rs2), .out_wb(out_wb), .out_illegal(out_illegal),
    .decode_cnt(decode_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mdec(logic [31:0] i);
    rec_t r;
    int op, v;
    r = '{default: '0};
    op = int'(i[6:0]);
    if (op >= 1 && op <= 10) begin
      r.rd = i[11:7]; r.rs1 = i[19:15]; r.rs2 = i[24:20];
      r.alu = 4'(op); r.u = 1; r.wb = 1;
    end else if (op == 11 || op == 13) begin
      v = int'(i[31:20]);
      if (v >= 2048) v -= 4096;
      r.rd = i[11:7]; r.rs1 = i[19:15]; r.imm = 32'(v); r.alu = 4'(op); r.wb = 1;
    end else if (op == 12) begin
      v = int'(i[31:25]) * 32 + int'(i[11:7]);
      if (v >= 2048) v -= 4096;
      r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.imm = 32'(v); r.alu = 4'd12; r.u = 1;
    end else if (op == 14) begin
      v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      if (v >= 4096) v -= 8192;
      r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.imm = 32'(v); r.alu = 4'd14; r.u = 1;
    end else r.ill = 1;
    if (r.rd == 0) r.wb = 0;
    return r;
  endfunction

  function automatic logic [63:0] pack(rec_t r);
    return {10'd0, r.rd, r.rs1, r.rs2, r.imm, r.alu, r.u, r.wb, r.ill};
  endfunction

  // model: advance the expected FIFO contents on every edge
  always @(posedge clk or posedge rst) begin
    rec_t r;
    bit pu, po;
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else if (flush) q.delete();
    else begin
      pu = in_valid && q.size() < 2;
      po = q.size() > 0 && out_ready;
      if (po) begin q.delete(0); pops++; end
      if (pu) begin
        r = mdec(in_instr);
        q.push_back(r);
        if (!r.ill) mcnt = (mcnt + 1) % 65536;
      end
    end
  end

  // compare: check DUT against model away from the active edge
  always @(negedge clk) begin
    rec_t z;
    z = '{default: '0};
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("decode_cnt", decode_cnt, mcnt);
    if (q.size() > 0)
      chk("head", {10'd0, out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_uses_rs2, out_wb, out_illegal}, pack(q[0]));
    else if (rst)
      chk("reset_fields", {10'd0, out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_uses_rs2, out_wb, out_illegal}, pack(z));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] x);
    bit r;
    r = 0;
    in_valid = 1;
    in_instr = x;
    for (int n = 0; n < 20 && !r; n++) begin
      @(negedge clk);
      r = in_ready;
      cyc();
    end
    if (!r) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    repeat (3) cyc();
    out_ready = 0;
  endtask

  localparam logic [31:0] ADD  = 32'h00A28301;
  localparam logic [31:0] SUB  = 32'h01FF8F82;
  localparam logic [31:0] SLT  = 32'h00C58709;
  localparam logic [31:0] SW   = 32'hFE52AE0C;
  localparam logic [31:0] LW   = 32'h8002A18B;
  localparam logic [31:0] ADDI = 32'hFFF0000D;
  localparam logic [31:0] BEQ  = 32'h0000008E;

  logic [31:0] mix [10] = '{32'h40C68788, 32'h00000000, 32'h8000000E, 32'h7FF3A38D,
                           32'h0000000F, 32'h0031A585, 32'hF8F1F30E, 32'h0062C20A,
                           32'h8A1B2C0C, 32'h00E7F686};
  int saved, p0;
  bit r;

  initial begin
    chk("model_beq_imm", mdec(BEQ).imm, 32'h800);
    chk("model_beq_neg", mdec(32'h8000000E).imm, 32'hFFFFF000);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_cnt", decode_cnt, 0);
    @(posedge clk);
    cyc();
    rst = 0;
    out_ready = 1;
    send(ADD);
    chk("add_valid", out_valid, 1);
    chk("add_fields", {out_rd, out_rs1, out_rs2, out_alu_op, out_uses_rs2, out_wb}, {5'd6, 5'd5, 5'd10, 4'd1, 1'b1, 1'b1});
    chk("add_cnt", decode_cnt, 1);
    cyc();
    out_ready = 0;
    send(SW);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_rd_wb", {out_rd, out_wb}, 0);
    drain();
    send(LW);
    chk("lw_imm", out_imm, 32'hFFFFF800);
    drain();
    send(BEQ);
    chk("beq_imm", out_imm, 32'h800);
    chk("beq_rd_wb", {out_rd, out_wb}, 0);
    drain();
    send(ADDI);
    chk("addi_rd0_wb", {out_imm, out_wb}, {32'hFFFFFFFF, 1'b0});
    drain();
    p0 = pops;
    send(ADD);
    send(SUB);
    chk("stall_ready", in_ready, 0);
    in_valid = 1;
    in_instr = SLT;
    repeat (3) begin
      cyc();
      chk("stall_ready_hold", in_ready, 0);
      chk("stall_head_hold", {out_rd, out_alu_op}, {5'd6, 4'd1});
    end
    out_ready = 1;
    r = 0;
    for (int n = 0; n < 10 && !r; n++) begin
      @(negedge clk);
      r = in_ready;
      cyc();
    end
    if (!r) chk("stall_accept_timeout", 0, 1);
    in_valid = 0;
    repeat (4) cyc();
    chk("stall_drained", pops - p0, 3);
    out_ready = 0;
    send(ADD);
    send(LW);
    saved = mcnt;
    flush = 1;
    in_valid = 1;
    in_instr = ADDI;
    cyc();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", decode_cnt, saved);
    saved = mcnt;
    send(32'hFFFFFFFF);
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_fields", {out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_uses_rs2, out_wb}, 0);
    chk("illegal_cnt", decode_cnt, saved);
    drain();
    foreach (mix[k]) begin
      out_ready = (k % 3) != 0;
      send(mix[k]);
    end
    drain();
    send(ADD);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", decode_cnt, 0);
    cyc();
    rst = 0;
    send(SUB);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_cnt", decode_cnt, 1);
    drain();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32: width of the sign-extended immediate output, legal range 16..64.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the decoded-instruction counter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- flush  in  1  discard all buffered and incoming instructions
- out_valid  out  1  decoded record valid
- out_ready  in  1  downstream accepts record
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate
- out_alu_op  out  4  operation code
- out_uses_rs2  out  1  record reads rs2
- out_wb  out  1  record writes rd
- out_illegal  out  1  unrecognised opcode
- decode_cnt  out  CNT_W  count of legal instructions accepted

Function
REQ-005 SHALL buffer decoded records in a 2-entry FIFO; the outputs show the head entry.
REQ-006 SHALL drive in_ready = (occupancy < 2) purely from registered state, with no combinational path from out_ready.
REQ-007 SHALL push on the clk edge where in_valid && in_ready && !flush, and pop on the edge where out_valid && out_ready && !flush.
REQ-008 SHALL allow push and pop on the same edge, leaving occupancy unchanged and preserving order.
REQ-009 SHALL assert out_valid on the edge after a push into an empty FIFO (latency 1 cycle), and deassert it when occupancy reaches 0.
REQ-010 SHALL hold all head fields stable while out_valid && !out_ready.
REQ-011 SHALL decode opcode = in_instr[6:0] combinationally at push time, with rd = [11:7], rs1 = [19:15] and rs2 = [24:20].
REQ-012 SHALL decode opcodes 1-10 (ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU) as register-register operations:
- alu_op = opcode[3:0]
- imm = 0
- uses_rs2 = 1
- wb = 1
REQ-013 SHALL decode opcode 11 (LW) as:
- imm = sext(instr[31:20])
- rs2 = 0, uses_rs2 = 0
- alu_op = 11
- wb = 1
REQ-014 SHALL decode opcode 12 (SW) as:
- imm = sext({instr[31:25], instr[11:7]}), a concatenation, not a sum
- rd = 0
- uses_rs2 = 1
- alu_op = 12
- wb = 0
REQ-015 SHALL decode opcode 13 (ADDI) as:
- imm = sext(instr[31:20])
- rs2 = 0, uses_rs2 = 0
- alu_op = 13
- wb = 1
REQ-016 SHALL decode opcode 14 (BEQ) as:
- imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
- rd = 0
- uses_rs2 = 1
- alu_op = 14
- wb = 0
REQ-017 SHALL force wb = 0 whenever the decoded rd = 0.
REQ-018 SHALL enqueue any other opcode as an illegal record:
- illegal = 1
- every other field 0
REQ-019 SHALL increment decode_cnt by 1 per push of a legal record, wrapping modulo 2^CNT_W; illegal records and flush do not change it.
REQ-020 SHALL, when flush is high on an edge:
- empty the FIFO
- drop any concurrent push
- block any concurrent pop
- give out_valid = 0 and in_ready = 1 next cycle

Reset
REQ-021 SHALL, while rst is high and without waiting for clk:
- empty the FIFO
- drive out_valid = 0, in_ready = 1 and decode_cnt = 0
- drive all out_* data fields to 0
REQ-022 SHALL discard buffered records when rst is asserted mid-operation, and accept input on the first clk edge after rst falls.

Verification
REQ-023 SHALL verify ADD latency: push 0x00A28301 with out_ready = 1 -> next cycle out_valid = 1, rd = 6, rs1 = 5, rs2 = 10, alu_op = 1, uses_rs2 = 1, wb = 1, decode_cnt = 1.
REQ-024 SHALL verify immediate decoding:
- SW 0xFE52AE0C -> imm = 0xFFFFFFFC (-4), rd = 0, wb = 0
- LW 0x8002A18B -> imm = 0xFFFFF800
REQ-025 SHALL verify stall: hold out_ready = 0 and offer 3 back-to-back instructions -> in_ready falls after 2 pushes, and the head is held stable; then raise out_ready -> records drain in order with no loss or duplication.
REQ-026 SHALL verify flush: with 2 records buffered and in_valid = 1, pulse flush -> next cycle out_valid = 0, in_ready = 1, decode_cnt unchanged.
REQ-027 SHALL verify illegal opcode: push opcode 0x7F -> out_illegal = 1, all other fields 0, decode_cnt unchanged.
REQ-028 SHALL verify asynchronous reset: assert rst between clk edges with 1 record buffered -> out_valid = 0 and decode_cnt = 0 before the next edge.
